// File: rtl/decoder_3_8_seq_pkg.sv
// decoder_3_8_seq_pkg: shared state encoding and widths for the sequenced 3-to-8 decoder.
package decoder_3_8_seq_pkg;
   localparam int ONEHOT_W = 8;
   localparam int IDX_W = 3;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;
endpackage

// File: rtl/decoder_3_8_seq_if.sv
// decoder_3_8_seq_if: index handshake in, one-hot pulse out.
interface decoder_3_8_seq_if;
   import decoder_3_8_seq_pkg::*;
   logic en;
   logic v_in;
   logic [IDX_W-1:0] in;
   logic rdy;
   logic [ONEHOT_W-1:0] out;
   logic v_out;
   logic done;
   modport master (output en, v_in, in, input rdy, out, v_out, done);
   modport slave (input en, v_in, in, output rdy, out, v_out, done);
endinterface

// File: rtl/decoder_3_8_seq_dec.sv
// dec_3_8_comb: pure combinational 3-to-8 one-hot decode.
module dec_3_8_comb
   import decoder_3_8_seq_pkg::*;
(
   input  logic [IDX_W-1:0]    idx,
   output logic [ONEHOT_W-1:0] onehot
);
   assign onehot = ONEHOT_W'(1) << idx;
endmodule

// File: rtl/decoder_3_8_seq.sv
// decoder_3_8_seq: accepts an index, drives its one-hot line for HOLD_CYCLES, then idles GAP_CYCLES.
module decoder_3_8_seq
   import decoder_3_8_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input logic clk,
   input logic rst,
   decoder_3_8_seq_if.slave bus
);
   localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW = ($clog2(MAX_C + 1) < 1) ? 1 : $clog2(MAX_C + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   state_t state, nxt;
   logic [CW-1:0] cnt, cnt_n;
   logic [IDX_W-1:0] code, code_n;
   logic [ONEHOT_W-1:0] dec_out;
   logic done_n;
   dec_3_8_comb u_dec (.idx(code_n), .onehot(dec_out));
   assign bus.rdy = bus.en && (state == IDLE);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         code <= '0;
         bus.out <= '0;
         bus.v_out <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= cnt_n;
         code <= code_n;
         bus.out <= (nxt == DRIVE) ? dec_out : '0;
         bus.v_out <= (nxt == DRIVE);
         bus.done <= done_n;
      end
   end
   // Outputs are registered from the next state, so out follows the accept edge by one cycle.
   always_comb begin
      nxt = state;
      cnt_n = cnt;
      code_n = code;
      done_n = 1'b0;
      if (!bus.en) begin
         nxt = IDLE;
         cnt_n = '0;
      end else begin
         case (state)
            IDLE: if (bus.v_in) begin
               nxt = DRIVE;
               cnt_n = HOLD_LD;
               code_n = bus.in;
            end
            DRIVE: if (cnt == '0) begin
               done_n = 1'b1;
               nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
               cnt_n = (GAP_CYCLES > 0) ? GAP_LD : '0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
            GAP: if (cnt == '0) begin
               nxt = IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
            default: nxt = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_decoder_3_8_seq.sv
// tb_decoder_3_8_seq: directed table plus corner sequences for three parameter sets.
module tb_decoder_3_8_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;

   decoder_3_8_seq_if ia ();
   decoder_3_8_seq_if ib ();
   decoder_3_8_seq_if ic ();
   decoder_3_8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) ua (.clk(clk), .rst(rst), .bus(ia));
   decoder_3_8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) ub (.clk(clk), .rst(rst), .bus(ib));
   decoder_3_8_seq #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) uc (.clk(clk), .rst(rst), .bus(ic));

   typedef struct {
      logic en;
      logic v;
      logic [2:0] idx;
      logic [7:0] out;
      logic vo;
      logic dn;
      logic rdy;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   function automatic vec_t mk(logic en, logic v, logic [2:0] idx, logic [7:0] out, logic vo, logic dn, logic rdy);
      vec_t r;
      r.en = en; r.v = v; r.idx = idx; r.out = out; r.vo = vo; r.dn = dn; r.rdy = rdy;
      return r;
   endfunction

   initial begin
      int dcnt;
      logic [2:0] idx;
      ia.en = 1'b1; ia.v_in = 1'b0; ia.in = '0;
      ib.en = 1'b0; ib.v_in = 1'b0; ib.in = '0;
      ic.en = 1'b0; ic.v_in = 1'b0; ic.in = '0;
      // single decode of 5
      vt.push_back(mk(1, 1, 5, 8'h00, 0, 0, 1));
      for (int i = 0; i < 4; i++) vt.push_back(mk(1, 0, 0, 8'h20, 1, 0, 0));
      vt.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0));
      vt.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1));
      // index 2 accepted, 7 presented while busy
      vt.push_back(mk(1, 1, 2, 8'h00, 0, 0, 1));
      for (int i = 0; i < 4; i++) vt.push_back(mk(1, 1, 7, 8'h04, 1, 0, 0));
      vt.push_back(mk(1, 1, 7, 8'h00, 0, 1, 0));
      vt.push_back(mk(1, 1, 7, 8'h00, 0, 0, 1));
      for (int i = 0; i < 4; i++) vt.push_back(mk(1, 0, 0, 8'h80, 1, 0, 0));
      vt.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0));
      vt.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1));
      // enable abort during second drive cycle of index 6
      vt.push_back(mk(1, 1, 6, 8'h00, 0, 0, 1));
      vt.push_back(mk(1, 0, 0, 8'h40, 1, 0, 0));
      vt.push_back(mk(0, 0, 0, 8'h40, 1, 0, 0));
      vt.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0));
      vt.push_back(mk(1, 1, 1, 8'h00, 0, 0, 1));
      for (int i = 0; i < 4; i++) vt.push_back(mk(1, 0, 0, 8'h02, 1, 0, 0));
      vt.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0));
      vt.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1));

      // asynchronous reset applied mid-cycle
      #3 rst = 1'b1;
      #1 chk("reset_out", {ia.out, ia.v_out, ia.done}, 10'h000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("reset_rdy", ia.rdy, 1);

      foreach (vt[i]) begin
         @(negedge clk);
         ia.en = vt[i].en; ia.v_in = vt[i].v; ia.in = vt[i].idx;
         #1 chk($sformatf("vec%0d", i), {ia.out, ia.v_out, ia.done, ia.rdy},
                {vt[i].out, vt[i].vo, vt[i].dn, vt[i].rdy});
      end

      // exhaustive sweep with v_in held high: period of 6 cycles per index
      idx = 3'd0;
      dcnt = 0;
      for (int c = 0; c < 48; c++) begin
         int p, k;
         p = c % 6;
         k = c / 6;
         @(negedge clk);
         ia.en = 1'b1; ia.v_in = 1'b1; ia.in = idx;
         #1;
         if (ia.done) dcnt++;
         chk($sformatf("sweep%0d", c), {ia.out, ia.v_out, ia.done},
             {((p >= 1 && p <= 4) ? (8'h01 << k) : 8'h00), (p >= 1 && p <= 4), (p == 5)});
         if (ia.rdy) idx = idx + 3'd1;
      end
      chk("sweep_dones", dcnt, 8);
      ia.v_in = 1'b0;

      // reset mid-pulse clears immediately
      @(negedge clk);
      ia.v_in = 1'b1; ia.in = 3'd4;
      @(negedge clk);
      ia.v_in = 1'b0;
      #1 chk("pre_rst_out", ia.out, 8'h10);
      #2 rst = 1'b1;
      #1 chk("midrst_out", {ia.out, ia.v_out, ia.done}, 10'h000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1 chk("postrst", {ia.out, ia.done, ia.rdy}, 10'h001);

      // HOLD=1, GAP=0: alternate one-hot and zero, done on every zero after the first
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         ib.en = 1'b1; ib.v_in = 1'b1; ib.in = 3'd3;
         #1 chk($sformatf("h1g0_%0d", c), {ib.out, ib.v_out, ib.done, ib.rdy},
                (c % 2 == 1) ? {8'h08, 1'b1, 1'b0, 1'b0} : {8'h00, 1'b0, (c > 0), 1'b1});
      end

      // HOLD=3, GAP=2: 3 wide pulses, 3 zero cycles between
      for (int c = 0; c < 12; c++) begin
         int p;
         p = c % 6;
         @(negedge clk);
         ic.en = 1'b1; ic.v_in = 1'b1; ic.in = 3'd6;
         #1 chk($sformatf("h3g2_%0d", c), {ic.out, ic.v_out, ic.done, ic.rdy},
                {((p >= 1 && p <= 3) ? 8'h40 : 8'h00), (p >= 1 && p <= 3), (p == 4), (p == 0)});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/decoder_3_8_seq.md
Name: decoder_3_8_seq

Overview:
- Sequenced 3-to-8 decoder: the decode side of the 8-to-3 priority-encoder path.
- Accepts a 3-bit index through a valid/ready handshake.
- Drives the matching one-hot line for a programmable number of cycles, then enforces a minimum off-gap before the next index is accepted.
- Sits downstream of the encoder to regenerate select/strobe lines from encoded requests.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot output is held asserted; must be >= 1.
- GAP_CYCLES, 1, idle cycles forced between two output pulses; must be >= 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset: asynchronous, active-high.
- en  input  1  block enable; 0 forces outputs inactive and aborts any pulse.
- v_in  input  1  input index valid.
- in  input  3  encoded index, 0..7.
- rdy  output  1  block can accept an index this cycle.
- out  output  8  one-hot decoded output, or all zeros.
- v_out  output  1  high exactly while out is non-zero.
- done  output  1  one-cycle pulse when a pulse completes normally.

Behaviour:
- Reset (async assert, sync release on clk):
  - state=IDLE, out=8'h00, v_out=0, done=0, counter=0, latched code=0.
- States: IDLE, DRIVE, GAP.
- rdy = en && (state==IDLE). It is combinational from registered state only and has no dependency on v_in.
- Accept: at an edge where en && v_in && rdy:
  - latch in as code;
  - state goes to DRIVE;
  - counter loads HOLD_CYCLES-1.
  - If v_in is high while rdy is low, the index is not accepted and is not stored. The source must hold it.
- Latency: out = (8'h01 << code) and v_out=1 from the cycle after accept.
- DRIVE:
  - out is held for exactly HOLD_CYCLES cycles.
  - Changes on in or v_in during DRIVE are ignored.
  - The counter decrements each cycle. When the counter is 0 at the edge, leave DRIVE.
  - Next state is GAP, with counter loaded GAP_CYCLES-1, if GAP_CYCLES>0. Otherwise the next state is IDLE.
- On leaving DRIVE normally:
  - out=0 and v_out=0 on the following cycle;
  - done=1 for that single cycle.
- GAP:
  - out=0 and rdy=0 for exactly GAP_CYCLES cycles, then IDLE.
  - With GAP_CYCLES=0, rdy rises in the same cycle as done. Back-to-back pulses are then separated by exactly one zero cycle (the accept cycle).
- en=0, in any state:
  - at the next edge: state=IDLE, out=0, v_out=0, counter=0;
  - no done pulse is generated;
  - rdy is 0 combinationally while en=0.
- en reasserted: resume from IDLE. The aborted index is discarded.
- Reset mid-pulse: out clears immediately (asynchronous) and no done is generated.
- At most one bit of out is ever set. out is 8'h00 whenever v_out=0.
- Counter width: clog2(max(HOLD_CYCLES, GAP_CYCLES)+1), with a minimum of 1 bit.
- All outputs except rdy are registered.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, DRIVE=2'd1, GAP=2'd2;
  - constant ONEHOT_W=8;
  - constant IDX_W=3.
- Optional sub-module dec_3_8_comb: pure combinational 3-to-8 one-hot decode (index in, 8-bit out). It is reusable and can be tested exhaustively on its own.
- Counter and FSM stay in the top module.

Test Plan:
- Reset and idle:
  - Stimulus: rst asserted mid-cycle with en=1, v_in=0.
  - Required: out=8'h00, v_out=0, done=0 immediately; rdy=1 after release.
- Single decode, defaults:
  - Stimulus: en=1, v_in=1, in=3'd5 for one cycle.
  - Required: from the next cycle, out=8'h20 and v_out=1 for 4 cycles. Then out=0 with done=1 for 1 cycle. rdy=0 throughout DRIVE and the 1 GAP cycle, then rdy=1.
- Exhaustive sweep:
  - Stimulus: indices 0..7 fed with v_in held high.
  - Required: out sequence 01,02,04,08,10,20,40,80. Each pulse is 4 cycles wide, pulses are separated by 2 zero cycles (gap + accept), and there are 8 done pulses.
- Input ignored while busy:
  - Stimulus: accept in=3'd2, then drive in=3'd7 with v_in=1 during DRIVE.
  - Required: out stays 8'h04 for 4 cycles. 7 is accepted only when rdy returns.
- Enable abort:
  - Stimulus: accept in=3'd6, then drop en during the 2nd DRIVE cycle.
  - Required: out=0 at the next edge, no done pulse, rdy=0 while en=0. Re-enable, then accept in=3'd1, giving out=8'h02.
- Parameter corners:
  - HOLD_CYCLES=1, GAP_CYCLES=0, continuous v_in: out alternates one-hot and zero each cycle, with done pulsing on every zero cycle.
  - HOLD_CYCLES=3, GAP_CYCLES=2: pulses are 3 cycles wide with 3 zero cycles between them.
